i2cm_byte: RTL and testbench
============================

# i2cm_byte

Byte-level I2C master sequencer sitting directly upstream of the `i2cm_bit` bit engine. It accepts one host request (optional START, one WRITE or READ byte with ACK phase, optional STOP), breaks it into bit commands, drives the bit engine's `cmd`/`tbit`/`clk_en`/`clr_n`, and collects `rbit`/`bdone`/`error`. It also owns the prescaler that paces the bit engine.

## Interface
- PRESC_W, 16, width of the prescale input
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- prescale  in  PRESC_W  clk_en period minus one; values 0 and 1 both give period 2
- req_valid  in  1  host request strobe, accepted only when `req_ready`=1
- req_ready  out  1  high in IDLE
- req_start / req_stop  in  1  prepend START / append STOP
- req_write / req_read  in  1  byte direction; write wins if both set; neither = START/STOP only
- req_ack  in  1  for reads: 1 = master drives ACK (SDA low), 0 = NACK
- wdata  in  8  byte to transmit, MSB first, latched at accept
- done  out  1  one-cycle pulse when request completes or aborts
- rdata  out  8  received byte, valid from `done`
- ack_rx  out  1  SDA sampled in write ACK slot (0 = slave ACK)
- err  out  1  valid with `done`; held until next accept
- bit_clk_en  out  1  one-cycle tick to bit engine
- bit_clr_n  out  1  `~rst`
- bit_cmd  out  5  bit command; NOP 5'h00, START 5'h01, STOP 5'h02, WRITE 5'h04, READ 5'h08 (shared define file)
- bit_tbit  out  1  bit to send
- bit_rbit / bit_bdone / bit_error  in  1  from bit engine

## Operation
- Prescaler: free-running down-counter; at 0 pulse `bit_clk_en` and reload max(prescale,1). Period ≥2 cycles guaranteed so a command updated the cycle after `bdone` is seen by the engine's next IDLE sample.
- States: IDLE, START, WBIT, WACK, RBIT, RACK, STOP, FIN.
- IDLE: on `req_valid`, latch all req fields and `wdata` into shift register, clear `err`, bit counter = 7; go to first of START / WBIT / RBIT / STOP / FIN (in that priority per request flags).
- Each non-FIN state holds `bit_cmd` (and `bit_tbit`) until `bit_bdone`; on the `bdone` cycle register next state and its command.
- START: cmd START. On bdone, if `bit_error` → abort, else go to WBIT/RBIT/STOP/FIN.
- WBIT: cmd WRITE, tbit = shreg[7]; on bdone shift left; after counter 0 → WACK.
- WACK: cmd READ; on bdone `ack_rx` <= `bit_rbit`; → STOP or FIN.
- RBIT: cmd READ; on bdone shift in `bit_rbit` at LSB; after counter 0 → RACK.
- RACK: cmd WRITE, tbit = ~req_ack; on bdone `rdata` <= shreg; → STOP or FIN.
- STOP: cmd STOP; on bdone `err` <= `bit_error`; → FIN.
- Bit errors on WRITE/READ bits are ignored (no arbitration support); only START/STOP errors count.
- Abort: `err`=1, `bit_cmd`=NOP, → FIN (no STOP issued).
- FIN: `bit_cmd`=NOP, pulse `done`, → IDLE.
- `bit_cmd` is NOP in IDLE and FIN, never otherwise.

## Timing
- Reset values: state IDLE, req_ready 1, done 0, rdata 8'h00, ack_rx 1, err 0, bit_cmd NOP, bit_tbit 1, bit_clk_en 0, prescale counter = max(prescale,1).
- Accept → first command on `bit_cmd` next cycle.
- Each bit costs 5 engine ticks (IDLE sample + 4 phases); `bdone` arrives 1 cycle after the 5th tick.
- `done` pulses 2 cycles after the final `bdone`; `req_ready` rises with the cycle after `done`.
- `req_valid` while not ready is ignored, not queued.
- `prescale` change takes effect at next reload.
- `rst` mid-request: immediate return to reset values; `bit_clr_n` low for the reset cycle(s).

## Test plan
- prescale=1, req start+write 0xA5, slave ACKs → bit_cmd sequence START, 8×WRITE tbit 1,0,1,0,0,1,0,1, READ; ack_rx=0, err=0, one done pulse.
- req read+stop, req_ack=0, slave drives 0x3C → 8×READ, WRITE tbit=1, STOP; rdata=0x3C, err=0.
- req start+write 0x50 with no slave (SDA pulled high in ACK slot) → ack_rx=1, err=0.
- SDA held low by bench during START → err=1 at done, no WRITE/STOP commands issued after START.
- prescale=0 vs 1 → identical bit_clk_en period of 2; prescale=9 → period 10, bit of 50 cycles.
- rst asserted mid-WBIT then released, new start+stop request → clean START, STOP, done, err=0.

Source files
------------

// File: rtl/i2cm_byte.sv
// Byte-level I2C master sequencer: turns one host request into bit commands
// for the downstream bit engine and owns the bit-engine prescaler.
module i2cm_byte #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_start,
    input  logic               req_stop,
    input  logic               req_write,
    input  logic               req_read,
    input  logic               req_ack,
    input  logic [7:0]         wdata,
    output logic               done,
    output logic [7:0]         rdata,
    output logic               ack_rx,
    output logic               err,
    output logic               bit_clk_en,
    output logic               bit_clr_n,
    output logic [4:0]         bit_cmd,
    output logic               bit_tbit,
    input  logic               bit_rbit,
    input  logic               bit_bdone,
    input  logic               bit_error
);

    localparam logic [4:0] CMD_NOP   = 5'h00;
    localparam logic [4:0] CMD_START = 5'h01;
    localparam logic [4:0] CMD_STOP  = 5'h02;
    localparam logic [4:0] CMD_WRITE = 5'h04;
    localparam logic [4:0] CMD_READ  = 5'h08;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WBIT, S_WACK,
        S_RBIT, S_RACK, S_STOP, S_FIN
    } state_t;

    state_t state, state_nx;

    logic [PRESC_W-1:0] pcnt;
    logic [PRESC_W-1:0] pload;
    logic               accept;
    logic               r_stop, r_write, r_read, r_ack;
    logic [7:0]         shreg;
    logic [2:0]         bcnt;

    // Reload floor of 1 keeps the tick period at two or more cycles
    assign pload = (prescale > PRESC_W'(1)) ? prescale : PRESC_W'(1);

    assign accept    = req_valid && req_ready;
    assign req_ready = (state == S_IDLE) && !done;
    assign bit_clr_n = ~rst;

    function automatic state_t first_state(
        input logic s, input logic w,
        input logic r, input logic p
    );
        if (s) return S_START;
        if (w) return S_WBIT;
        if (r) return S_RBIT;
        if (p) return S_STOP;
        return S_FIN;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (accept)
                    state_nx = first_state(req_start, req_write,
                                           req_read, req_stop);
            S_START:
                if (bit_bdone)
                    state_nx = bit_error ? S_FIN :
                        first_state(1'b0, r_write, r_read, r_stop);
            S_WBIT:
                if (bit_bdone && bcnt == 3'd0) state_nx = S_WACK;
            S_WACK:
                if (bit_bdone) state_nx = r_stop ? S_STOP : S_FIN;
            S_RBIT:
                if (bit_bdone && bcnt == 3'd0) state_nx = S_RACK;
            S_RACK:
                if (bit_bdone) state_nx = r_stop ? S_STOP : S_FIN;
            S_STOP:
                if (bit_bdone) state_nx = S_FIN;
            S_FIN:
                state_nx = S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bit_cmd  = CMD_NOP;
        bit_tbit = 1'b1;
        unique case (state)
            S_START: bit_cmd = CMD_START;
            S_WBIT: begin
                bit_cmd  = CMD_WRITE;
                bit_tbit = shreg[7];
            end
            S_WACK:  bit_cmd = CMD_READ;
            S_RBIT:  bit_cmd = CMD_READ;
            S_RACK: begin
                bit_cmd  = CMD_WRITE;
                bit_tbit = ~r_ack;
            end
            S_STOP:  bit_cmd = CMD_STOP;
            default: bit_cmd = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= pload;
            bit_clk_en <= 1'b0;
            done       <= 1'b0;
            rdata      <= 8'h00;
            ack_rx     <= 1'b1;
            err        <= 1'b0;
            shreg      <= 8'h00;
            bcnt       <= 3'd7;
            r_stop     <= 1'b0;
            r_write    <= 1'b0;
            r_read     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            bit_clk_en <= (pcnt == '0);
            pcnt       <= (pcnt == '0) ? pload : pcnt - PRESC_W'(1);
            done       <= (state == S_FIN);
            if (accept) begin
                r_stop  <= req_stop;
                r_write <= req_write;
                r_read  <= req_read && !req_write;
                r_ack   <= req_ack;
                shreg   <= wdata;
                err     <= 1'b0;
                bcnt    <= 3'd7;
            end
            // Bit errors during data bits are ignored: no arbitration
            if (bit_bdone) begin
                unique case (state)
                    S_START: if (bit_error) err <= 1'b1;
                    S_WBIT: begin
                        shreg <= {shreg[6:0], 1'b0};
                        bcnt  <= bcnt - 3'd1;
                    end
                    S_WACK:  ack_rx <= bit_rbit;
                    S_RBIT: begin
                        shreg <= {shreg[6:0], bit_rbit};
                        bcnt  <= bcnt - 3'd1;
                    end
                    S_RACK:  rdata <= shreg;
                    S_STOP:  err <= bit_error;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2cm_byte.sv
// Bench for i2cm_byte: a behavioural bit-engine/slave drives the DUT and
// each request is checked against the command list derived from its flags.
module tb_i2cm_byte;

    localparam logic [4:0] C_NOP   = 5'h00;
    localparam logic [4:0] C_START = 5'h01;
    localparam logic [4:0] C_STOP  = 5'h02;
    localparam logic [4:0] C_WRITE = 5'h04;
    localparam logic [4:0] C_READ  = 5'h08;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_start = 1'b0;
    logic        req_stop = 1'b0;
    logic        req_write = 1'b0;
    logic        req_read = 1'b0;
    logic        req_ack = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        done;
    logic [7:0]  rdata;
    logic        ack_rx;
    logic        err;
    logic        bit_clk_en;
    logic        bit_clr_n;
    logic [4:0]  bit_cmd;
    logic        bit_tbit;
    logic        bit_rbit = 1'b1;
    logic        bit_bdone = 1'b0;
    logic        bit_error = 1'b0;

    i2cm_byte #(.PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .prescale(prescale),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_start(req_start), .req_stop(req_stop),
        .req_write(req_write), .req_read(req_read),
        .req_ack(req_ack), .wdata(wdata), .done(done),
        .rdata(rdata), .ack_rx(ack_rx), .err(err),
        .bit_clk_en(bit_clk_en), .bit_clr_n(bit_clr_n),
        .bit_cmd(bit_cmd), .bit_tbit(bit_tbit),
        .bit_rbit(bit_rbit), .bit_bdone(bit_bdone),
        .bit_error(bit_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    logic [4:0] log_cmd[$];
    logic       log_tbit[$];
    int         log_cyc[$];
    logic       rbit_q[$];
    logic       start_err = 1'b0;
    logic       stop_err = 1'b0;
    int         last_bd = 0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_ack = 1'b1;

    // Bit engine: samples a command on a tick, spends 4 more ticks on it,
    // then pulses bdone one cycle after the fifth tick.
    initial begin : engine
        int ph;
        logic pend, perr, prbit;
        logic [4:0] cur;
        ph = 0; pend = 0; perr = 0; prbit = 1; cur = C_NOP;
        forever begin
            @(negedge clk);
            if (bit_clr_n !== 1'b1) begin
                ph = 0; pend = 0;
                bit_bdone = 1'b0; bit_error = 1'b0;
            end else begin
                if (bit_bdone) begin
                    bit_bdone = 1'b0; bit_error = 1'b0; ph = 0;
                end
                if (pend) begin
                    pend = 0;
                    bit_bdone = 1'b1;
                    bit_error = perr;
                    bit_rbit = prbit;
                    last_bd = ncyc;
                end else if (bit_clk_en === 1'b1) begin
                    if (ph == 0) begin
                        if (bit_cmd !== C_NOP) begin
                            cur = bit_cmd;
                            log_cmd.push_back(bit_cmd);
                            log_tbit.push_back(bit_tbit);
                            log_cyc.push_back(ncyc);
                            ph = 1;
                        end
                    end else if (ph < 5) begin
                        ph++;
                        if (ph == 5) begin
                            pend = 1;
                            perr = (cur == C_START && start_err) ||
                                   (cur == C_STOP && stop_err);
                            prbit = 1'b1;
                            if (cur == C_READ && rbit_q.size() > 0)
                                prbit = rbit_q.pop_front();
                        end
                    end
                end
            end
        end
    end

    task automatic do_req(
        input string nm,
        input logic s, input logic w, input logic r,
        input logic p, input logic a,
        input logic [7:0] wd, input logic [7:0] sb,
        input logic sa, input logic se, input logic pe,
        input logic spam
    );
        logic [4:0] ec[$];
        logic       et[$];
        logic       err_e;
        logic [4:0] first_e;
        int n;
        log_cmd.delete(); log_tbit.delete(); log_cyc.delete();
        rbit_q.delete();
        start_err = s & se;
        stop_err = pe;
        err_e = 1'b0;
        if (s) begin ec.push_back(C_START); et.push_back(1'b1); end
        if (s && se) begin
            err_e = 1'b1;
        end else begin
            if (w) begin
                for (int i = 7; i >= 0; i--) begin
                    ec.push_back(C_WRITE); et.push_back(wd[i]);
                end
                ec.push_back(C_READ); et.push_back(1'b1);
                rbit_q.push_back(sa);
                m_ack = sa;
            end else if (r) begin
                for (int i = 7; i >= 0; i--) begin
                    ec.push_back(C_READ); et.push_back(1'b1);
                    rbit_q.push_back(sb[i]);
                end
                ec.push_back(C_WRITE); et.push_back(~a);
                m_rdata = sb;
            end
            if (p) begin
                ec.push_back(C_STOP); et.push_back(1'b1);
                err_e = pe;
            end
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk); n++;
        end
        req_start = s; req_write = w; req_read = r;
        req_stop = p; req_ack = a; wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        first_e = (ec.size() > 0) ? ec[0] : C_NOP;
        total++;
        if (bit_cmd !== first_e)
            $display("FAIL %s first_cmd: got %h want %h", nm, bit_cmd, first_e);
        n = 0;
        while (1) begin
            @(negedge clk);
            if (done === 1'b1 || n >= 20000) break;
            if (spam) begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_start = 1'($urandom);
                wdata = 8'($urandom);
            end
            n++;
        end
        req_valid = 1'b0;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_timeout: got %b want 1", nm, done);
            return;
        end
        if (ec.size() > 0) begin
            total++;
            if (ncyc - last_bd != 2) begin
                bad++;
                $display("FAIL %s done_lat: got %0d want 2", nm, ncyc - last_bd);
            end
        end
        total++;
        if (err !== err_e || rdata !== m_rdata || ack_rx !== m_ack ||
            req_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s result: got err=%b rdata=%h ack=%b rdy=%b want err=%b rdata=%h ack=%b rdy=0",
                     nm, err, rdata, ack_rx, req_ready, err_e, m_rdata, m_ack);
        end
        total++;
        if (log_cmd.size() != ec.size()) begin
            bad++;
            $display("FAIL %s cmd_count: got %0d want %0d",
                     nm, log_cmd.size(), ec.size());
        end else begin
            for (int i = 0; i < ec.size(); i++) begin
                total++;
                if (log_cmd[i] !== ec[i] ||
                    (ec[i] == C_WRITE && log_tbit[i] !== et[i])) begin
                    bad++;
                    $display("FAIL %s cmd[%0d]: got %h/%b want %h/%b",
                             nm, i, log_cmd[i], log_tbit[i], ec[i], et[i]);
                end
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s after_done: got done=%b rdy=%b want done=0 rdy=1",
                     nm, done, req_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || done !== 1'b0 || rdata !== 8'h00 ||
            ack_rx !== 1'b1 || err !== 1'b0 || bit_cmd !== C_NOP ||
            bit_tbit !== 1'b1 || bit_clk_en !== 1'b0 || bit_clr_n !== 1'b0) begin
            bad++;
            $display("FAIL reset: got rdy=%b done=%b rd=%h ack=%b err=%b cmd=%h tb=%b en=%b clr=%b want 1 0 00 1 0 00 1 0 0",
                     req_ready, done, rdata, ack_rx, err, bit_cmd,
                     bit_tbit, bit_clk_en, bit_clr_n);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bit_clr_n !== 1'b1) begin
            bad++;
            $display("FAIL clr_n_release: got %b want 1", bit_clr_n);
        end
    endtask

    task automatic test_period(input logic [15:0] ps, input int expp);
        int n;
        prescale = ps;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end
            while (bit_clk_en !== 1'b1 && n < 100);
        end
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin @(negedge clk); n++; end
            while (bit_clk_en !== 1'b1 && n < 100);
            total++;
            if (n != expp) begin
                bad++;
                $display("FAIL period_ps%0d: got %0d want %0d", ps, n, expp);
            end
        end
    endtask

    task automatic test_prescale;
        test_period(16'd0, 2);
        test_period(16'd1, 2);
        test_period(16'd9, 10);
        do_req("ps9", 1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        total++;
        if (log_cyc.size() != 2 || log_cyc[1] - log_cyc[0] != 50) begin
            bad++;
            $display("FAIL bit_time_ps9: got %0d cmds, %0d cycles want 2, 50",
                     log_cyc.size(),
                     (log_cyc.size() == 2) ? log_cyc[1] - log_cyc[0] : -1);
        end
        prescale = 16'd1;
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        log_cmd.delete(); log_tbit.delete(); log_cyc.delete();
        rbit_q.delete();
        start_err = 0; stop_err = 0;
        req_start = 1; req_write = 1; req_read = 0; req_stop = 1;
        wdata = 8'hFF; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        n = 0;
        while (log_cmd.size() < 3 && n < 2000) begin @(negedge clk); n++; end
        total++;
        if (bit_cmd !== C_WRITE) begin
            bad++;
            $display("FAIL mid_wbit: got %h want %h", bit_cmd, C_WRITE);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bit_cmd !== C_NOP || req_ready !== 1'b1 || err !== 1'b0 ||
            done !== 1'b0 || bit_clr_n !== 1'b0 || ack_rx !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst: got cmd=%h rdy=%b err=%b done=%b clr=%b ack=%b want 00 1 0 0 0 1",
                     bit_cmd, req_ready, err, done, bit_clr_n, ack_rx);
        end
        rst = 1'b0;
        m_rdata = 8'h00;
        m_ack = 1'b1;
        repeat (2) @(negedge clk);
        do_req("after_rst", 1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    endtask

    task automatic test_random;
        logic s, w, r, p, a, sa, se, pe, sp;
        logic [7:0] wd, sb;
        for (int k = 0; k < 20; k++) begin
            prescale = 16'($urandom_range(0, 3));
            s = 1'($urandom); w = 1'($urandom); r = 1'($urandom);
            p = 1'($urandom); a = 1'($urandom); sa = 1'($urandom);
            se = ($urandom_range(0, 4) == 0);
            pe = ($urandom_range(0, 3) == 0);
            sp = 1'($urandom);
            wd = 8'($urandom); sb = 8'($urandom);
            do_req($sformatf("rand%0d", k), s, w, r, p, a, wd, sb,
                   sa, se, pe, sp);
        end
        prescale = 16'd1;
    endtask

    initial begin
        test_reset();
        do_req("write_a5", 1, 1, 0, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 0);
        do_req("read_3c", 0, 0, 1, 1, 0, 8'h00, 8'h3C, 1, 0, 0, 0);
        do_req("no_slave", 1, 1, 0, 0, 0, 8'h50, 8'h00, 1, 0, 0, 0);
        do_req("start_err", 1, 1, 0, 1, 0, 8'h77, 8'h00, 0, 1, 0, 0);
        do_req("stop_err", 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0);
        do_req("wr_wins", 1, 1, 1, 1, 1, 8'hC3, 8'h5A, 0, 0, 0, 1);
        do_req("busy_ignored", 0, 0, 1, 0, 1, 8'h00, 8'h96, 1, 0, 0, 1);
        do_req("empty", 0, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        test_prescale();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
